// File: rtl/aes_round_ctrl.sv
// AES round controller: sequences NROUNDS rounds of a per-round sequencer,
// tracks round number and key-schedule Rcon, and guards each round with a watchdog.
module aes_round_ctrl #(
    parameter int NROUNDS = 10,
    parameter int TIMEOUT = 31
) (
    input  logic       ClkxCI,
    input  logic       RstxBI,
    input  logic       ReqxSI,
    input  logic       AckxSI,
    input  logic       LastCyclexSI,
    output logic       StartxSO,
    output logic       LastRoundxSO,
    output logic [3:0] RoundxDO,
    output logic [7:0] RconxDO,
    output logic       BusyxSO,
    output logic       DonexSO,
    output logic       ErrxSO
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] LASTRND = 4'(NROUNDS);
    // Expiry fires on the edge where the count would reach TIMEOUT.
    localparam logic [7:0] WDLIM   = 8'(TIMEOUT - 1);

    state_t     StatexDP, StatexDN;
    logic [3:0] RoundxDP, RoundxDN;
    logic [7:0] RconxDP, RconxDN;
    logic [7:0] WdogxDP, WdogxDN;
    logic       ErrxSP, ErrxSN;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            StatexDP <= IDLE;
            RoundxDP <= 4'd0;
            RconxDP  <= 8'h00;
            WdogxDP  <= 8'd0;
            ErrxSP   <= 1'b0;
        end else begin
            StatexDP <= StatexDN;
            RoundxDP <= RoundxDN;
            RconxDP  <= RconxDN;
            WdogxDP  <= WdogxDN;
            ErrxSP   <= ErrxSN;
        end
    end

    always_comb begin
        StatexDN = StatexDP;
        RoundxDN = RoundxDP;
        RconxDN  = RconxDP;
        WdogxDN  = WdogxDP;
        ErrxSN   = ErrxSP;
        case (StatexDP)
            IDLE: begin
                if (LastCyclexSI) begin
                    ErrxSN = 1'b1;
                end else if (ReqxSI) begin
                    StatexDN = START;
                    ErrxSN   = 1'b0;
                    RoundxDN = 4'd1;
                    RconxDN  = 8'h01;
                end
            end
            START: begin
                // START is always a single cycle; a stray strobe only flags an error.
                if (LastCyclexSI) ErrxSN = 1'b1;
                StatexDN = RUN;
                WdogxDN  = 8'd0;
            end
            RUN: begin
                if (LastCyclexSI) begin
                    WdogxDN = 8'd0;
                    if (RoundxDP == LASTRND) begin
                        StatexDN = DONE;
                        RoundxDN = 4'd0;
                        RconxDN  = 8'h00;
                    end else begin
                        RoundxDN = RoundxDP + 4'd1;
                        RconxDN  = xtime(RconxDP);
                    end
                end else begin
                    if (WdogxDP != 8'hFF) WdogxDN = WdogxDP + 8'd1;
                    if (WdogxDP == WDLIM) begin
                        StatexDN = IDLE;
                        ErrxSN   = 1'b1;
                        RoundxDN = 4'd0;
                        RconxDN  = 8'h00;
                    end
                end
            end
            DONE: begin
                if (LastCyclexSI) begin
                    ErrxSN = 1'b1;
                end else if (AckxSI) begin
                    StatexDN = IDLE;
                end
            end
            default: StatexDN = IDLE;
        endcase
    end

    always_comb begin
        StartxSO     = (StatexDP == START);
        BusyxSO      = (StatexDP == START) || (StatexDP == RUN);
        DonexSO      = (StatexDP == DONE);
        ErrxSO       = ErrxSP;
        RoundxDO     = 4'd0;
        RconxDO      = 8'h00;
        LastRoundxSO = 1'b0;
        if (StatexDP == RUN) begin
            RoundxDO     = RoundxDP;
            RconxDO      = RconxDP;
            LastRoundxSO = (RoundxDP == LASTRND);
        end
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Scoreboard bench for aes_round_ctrl: default NROUNDS=10 instance plus an NROUNDS=1 instance.
module tb_aes_round_ctrl;

    localparam int NR0 = 10;

    logic ClkxC = 1'b0;
    always #5 ClkxC = ~ClkxC;

    logic       RstxB;
    logic       req0, ack0, last0, start0, lr0, busy0, done0, err0;
    logic [3:0] rnd0;
    logic [7:0] rc0;
    logic       req1, ack1, last1, start1, lr1, busy1, done1, err1;
    logic [3:0] rnd1;
    logic [7:0] rc1;

    aes_round_ctrl #(.NROUNDS(NR0), .TIMEOUT(31)) u0 (
        .ClkxCI(ClkxC), .RstxBI(RstxB), .ReqxSI(req0), .AckxSI(ack0),
        .LastCyclexSI(last0), .StartxSO(start0), .LastRoundxSO(lr0),
        .RoundxDO(rnd0), .RconxDO(rc0), .BusyxSO(busy0), .DonexSO(done0), .ErrxSO(err0)
    );

    aes_round_ctrl #(.NROUNDS(1), .TIMEOUT(31)) u1 (
        .ClkxCI(ClkxC), .RstxBI(RstxB), .ReqxSI(req1), .AckxSI(ack1),
        .LastCyclexSI(last1), .StartxSO(start1), .LastRoundxSO(lr1),
        .RoundxDO(rnd1), .RconxDO(rc1), .BusyxSO(busy1), .DonexSO(done1), .ErrxSO(err1)
    );

    int total = 0;
    int bad   = 0;
    int startCnt = 0;
    int doneCnt  = 0;
    logic doneQ = 1'b0;
    logic [11:0] sbq[$];
    logic [7:0] RCON[10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

    always @(negedge ClkxC) begin
        if (start0) startCnt++;
        if (done0 && !doneQ) doneCnt++;
        doneQ = done0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge ClkxC);
        #1;
    endtask

    task automatic start_op();
        for (int r = 1; r <= NR0; r++) sbq.push_back({4'(r), RCON[r-1]});
        req0 = 1'b1;
        step();
        req0 = 1'b0;
        chk("start_pulse", start0, 1'b1);
        chk("start_busy", busy0, 1'b1);
        chk("start_rnd0", rnd0, 4'd0);
        chk("start_err_clr", err0, 1'b0);
        step();
        chk("run_no_start", start0, 1'b0);
        chk("run_busy", busy0, 1'b1);
    endtask

    task automatic run_rounds(input int gap0, input int n);
        logic [11:0] e;
        for (int r = 1; r <= n; r++) begin
            repeat ((r == 1) ? gap0 : 23) step();
            chk("sbq_nonempty", sbq.size() != 0, 1'b1);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("rnd", rnd0, e[11:8]);
                chk("rcon", rc0, e[7:0]);
                chk("lastrnd", lr0, r == NR0);
                chk("run_err", err0, 1'b0);
                chk("run_nostart", start0, 1'b0);
            end
            last0 = 1'b1;
            step();
            last0 = 1'b0;
        end
        if (n == NR0) begin
            chk("done", done0, 1'b1);
            chk("done_busy", busy0, 1'b0);
            chk("done_rnd", rnd0, 4'd0);
            chk("done_rcon", rc0, 8'h00);
            chk("done_lr", lr0, 1'b0);
        end
    endtask

    task automatic ack_op();
        req0 = 1'b1;
        repeat (3) step();
        req0 = 1'b0;
        chk("done_hold", done0, 1'b1);
        chk("done_req_ign", start0, 1'b0);
        ack0 = 1'b1;
        step();
        ack0 = 1'b0;
        chk("ack_idle_done", done0, 1'b0);
        chk("ack_idle_busy", busy0, 1'b0);
    endtask

    task automatic chk_zero0(input string tag);
        chk({tag, "_start"}, start0, 1'b0);
        chk({tag, "_lr"}, lr0, 1'b0);
        chk({tag, "_rnd"}, rnd0, 4'd0);
        chk({tag, "_rcon"}, rc0, 8'h00);
        chk({tag, "_busy"}, busy0, 1'b0);
        chk({tag, "_done"}, done0, 1'b0);
        chk({tag, "_err"}, err0, 1'b0);
    endtask

    int s, d;

    initial begin
        RstxB = 1'b0;
        req0 = 0; ack0 = 0; last0 = 0;
        req1 = 0; ack1 = 0; last1 = 0;
        repeat (3) @(posedge ClkxC);
        #1;
        chk_zero0("rst");
        chk("rst_u1_busy", busy1, 1'b0);
        RstxB = 1'b1;
        step();
        chk_zero0("idle");

        // nominal operation
        s = startCnt; d = doneCnt;
        start_op();
        run_rounds(23, NR0);
        chk("nom_start_cnt", startCnt, s + 1);
        ack_op();
        chk("nom_done_cnt", doneCnt, d + 1);

        // spurious strobe in IDLE
        last0 = 1'b1;
        step();
        last0 = 1'b0;
        chk("spur_err", err0, 1'b1);
        chk("spur_busy", busy0, 1'b0);
        chk("spur_done", done0, 1'b0);
        step();
        chk("spur_sticky", err0, 1'b1);

        // watchdog timeout: 31 RUN cycles without a strobe
        d = doneCnt;
        start_op();
        repeat (30) step();
        chk("to_still_run", busy0, 1'b1);
        chk("to_no_err_yet", err0, 1'b0);
        step();
        chk("to_err", err0, 1'b1);
        chk("to_idle", busy0, 1'b0);
        chk("to_rnd", rnd0, 4'd0);
        chk("to_done", done0, 1'b0);
        sbq.delete();
        start_op();
        run_rounds(23, NR0);
        ack_op();
        chk("to_done_cnt", doneCnt, d + 1);

        // strobe coincident with watchdog expiry
        start_op();
        run_rounds(30, NR0);
        chk("coin_err", err0, 1'b0);
        // back-to-back with Req held through Ack
        req0 = 1'b1;
        ack0 = 1'b1;
        step();
        ack0 = 1'b0;
        chk("b2b_idle_done", done0, 1'b0);
        chk("b2b_idle_busy", busy0, 1'b0);
        chk("b2b_idle_start", start0, 1'b0);
        start_op();
        run_rounds(23, NR0);
        ack_op();

        // reset during round 5
        start_op();
        run_rounds(23, 4);
        repeat (5) step();
        chk("r5_rnd", rnd0, 4'd5);
        s = startCnt; d = doneCnt;
        RstxB = 1'b0;
        #2;
        chk_zero0("arst");
        step();
        chk_zero0("arst_hold");
        RstxB = 1'b1;
        sbq.delete();
        chk("arst_start_cnt", startCnt, s);
        chk("arst_done_cnt", doneCnt, d);
        start_op();
        run_rounds(23, NR0);
        ack_op();

        // NROUNDS=1 instance
        req1 = 1'b1;
        step();
        req1 = 1'b0;
        chk("n1_start", start1, 1'b1);
        step();
        chk("n1_lr", lr1, 1'b1);
        chk("n1_rnd", rnd1, 4'd1);
        chk("n1_rcon", rc1, 8'h01);
        repeat (23) step();
        chk("n1_lr_hold", lr1, 1'b1);
        last1 = 1'b1;
        step();
        last1 = 1'b0;
        chk("n1_done", done1, 1'b1);
        chk("n1_done_rnd", rnd1, 4'd0);
        chk("n1_done_lr", lr1, 1'b0);
        ack1 = 1'b1;
        step();
        ack1 = 1'b0;
        chk("n1_ack", done1, 1'b0);
        chk("n1_err", err1, 1'b0);

        chk("sbq_drained", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
